i_mem_ctrl: RTL

I_MEM_CTRL -- requirements
Module: i_mem_ctrl

---
 rtl/i_mem_ctrl.sv | 119 +++++++++++
 1 files changed

// File: rtl/i_mem_ctrl.sv
// Instruction-memory controller: fixed-latency read FSM over a backdoor-loaded word array.
// Optional build macro I_MEM_CTRL_ABORT_EN lets a dropped m_strobe in WAIT abandon the read.
module i_mem_ctrl #(
  parameter int LATENCY   = 3,
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 clrn,
  input  logic [31:0]          m_a,
  input  logic                 m_strobe,
  output logic [31:0]          m_dout,
  output logic                 m_ready,
  output logic                 busy,
  input  logic                 ld_we,
  input  logic [ADDR_BITS-1:0] ld_a,
  input  logic [31:0]          ld_d
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] WAIT   = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;
  localparam int         DEPTH  = 1 << ADDR_BITS;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  logic [1:0]           state_r;
  logic [1:0]           state_s;
  logic [3:0]           cnt_r;
  logic [3:0]           cnt_s;
  logic [ADDR_BITS-1:0] a_reg_r;
  logic [ADDR_BITS-1:0] a_reg_s;
  logic                 load_dout_s;
  logic [31:0]          m_dout_r;
  logic                 m_ready_r;
  logic                 busy_r;
  logic [31:0]          mem_r [0:DEPTH-1];

  // Byte-lane and above-array address bits alias away by design.
  logic unused_addr_s;
  assign unused_addr_s = ^{m_a[31:ADDR_BITS+2], m_a[1:0]};

  // Next-state, counter and address-capture logic.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    a_reg_s     = a_reg_r;
    load_dout_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (m_strobe) begin
          state_s = WAIT;
          cnt_s   = LAT_M1;
          a_reg_s = m_a[ADDR_BITS+1:2];
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
`ifdef I_MEM_CTRL_ABORT_EN
        if (!m_strobe) begin
          state_s = IDLE;
        end else if (cnt_r != 4'd0) begin
          cnt_s = cnt_r - 4'd1;
        end else begin
          state_s     = RESP;
          load_dout_s = 1'b1;
        end
`else
        if (cnt_r != 4'd0) begin
          cnt_s = cnt_r - 4'd1;
        end else begin
          state_s     = RESP;
          load_dout_s = 1'b1;
        end
`endif
      end
      RESP: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Control state and registered outputs; outputs track the next state so they align with it.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_r   <= IDLE;
      cnt_r     <= 4'd0;
      a_reg_r   <= '0;
      m_dout_r  <= 32'd0;
      m_ready_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      a_reg_r   <= a_reg_s;
      m_ready_r <= (state_s == RESP);
      busy_r    <= (state_s != IDLE);
      if (load_dout_s) begin
        m_dout_r <= mem_r[a_reg_r];
      end else begin
        m_dout_r <= m_dout_r;
      end
    end
  end

  // Backing array: never reset; a same-edge load is seen only by later reads.
  always_ff @(posedge clk) begin
    if (ld_we) begin
      mem_r[ld_a] <= ld_d;
    end
  end

  assign m_dout  = m_dout_r;
  assign m_ready = m_ready_r;
  assign busy    = busy_r;

endmodule
